// File: rtl/debounce_pkg.sv
// Shared types and defaults for the multi-channel debounce sequencer.
// Optional input synchroniser is enabled with the DEBOUNCE_SYNC_EN macro.
package debounce_pkg;

    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        PRESS   = 6'b000010,
        HOLD_HI = 6'b000100,
        WAIT_LO = 6'b001000,
        RELEASE = 6'b010000,
        HOLD_LO = 6'b100000
    } state_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: press/hold/release FSM with its own hold counter.
// DEBOUNCE_SYNC_EN inserts a 2-flop synchroniser in front of the FSM.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [CNT_W-1:0] hold_ticks,
    input  logic             x,
    output logic             q,
    output logic             rel,
    output logic             level,
    output logic             busy
);

    logic x_s;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], x};
        end
    end

    assign x_s = sync_q[1];
`else
    assign x_s = x;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, rel_q, level_q, busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (x_s) state_d = PRESS;
            PRESS: begin
                state_d = HOLD_HI;
                cnt_d   = hold_ticks;
            end
            HOLD_HI: begin
                if (cnt_q == '0)  state_d = WAIT_LO;
                else if (tick)    cnt_d   = cnt_q - 1'b1;
            end
            WAIT_LO: if (!x_s) state_d = RELEASE;
            RELEASE: begin
                state_d = HOLD_LO;
                cnt_d   = hold_ticks;
            end
            HOLD_LO: begin
                if (cnt_q == '0)  state_d = IDLE;
                else if (tick)    cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rel_q   <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= (state_d == PRESS);
            rel_q   <= (state_d == RELEASE);
            level_q <= (state_d == PRESS) || (state_d == HOLD_HI) || (state_d == WAIT_LO);
            busy_q  <= (state_d == HOLD_HI) || (state_d == HOLD_LO);
        end
    end

    assign q     = q_q;
    assign rel   = rel_q;
    assign level = level_q;
    assign busy  = busy_q;

endmodule

// File: rtl/debounce_timer_fsm.sv
// Multi-channel debounce sequencer: one independent debounce_channel per input bit.
// Build with DEBOUNCE_SYNC_EN to synchronise raw inputs inside each channel.
module debounce_timer_fsm
    import debounce_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [CNT_W-1:0]    hold_ticks,
    input  logic [CHANNELS-1:0] X,
    output logic [CHANNELS-1:0] Q,
    output logic [CHANNELS-1:0] REL,
    output logic [CHANNELS-1:0] LEVEL,
    output logic [CHANNELS-1:0] BUSY
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            debounce_channel #(
                .CNT_W(CNT_W)
            ) u_ch (
                .clk        (clk),
                .reset      (reset),
                .tick       (tick),
                .hold_ticks (hold_ticks),
                .x          (X[gi]),
                .q          (Q[gi]),
                .rel        (REL[gi]),
                .level      (LEVEL[gi]),
                .busy       (BUSY[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_timer_fsm.sv
// Table-driven bench for debounce_timer_fsm; expected outputs are hand-derived cycle by cycle.
module tb_debounce_timer_fsm;

    localparam int CH = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic [CW-1:0] hold_ticks;
    logic [CH-1:0] X, Q, REL, LEVEL, BUSY;

    always #5 clk = ~clk;

    debounce_timer_fsm #(.CHANNELS(CH), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .hold_ticks (hold_ticks),
        .X          (X),
        .Q          (Q),
        .REL        (REL),
        .LEVEL      (LEVEL),
        .BUSY       (BUSY)
    );

    typedef struct {
        logic          rst;
        logic          tk;
        logic [CW-1:0] ht;
        logic [CH-1:0] x;
        logic [CH-1:0] eq, erel, elev, ebusy;
        int            id;
    } vec_t;

    vec_t  vecs[$];
    vec_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    step_no = 0;
    string names[8] = '{"reset", "basic", "bounce", "tickgate", "htchange",
                        "multi", "longhold", "rst_hold_lo"};

    function automatic void add(input logic r, input logic tk, input logic [CW-1:0] ht,
                                input logic [CH-1:0] x, input logic [CH-1:0] q,
                                input logic [CH-1:0] rl, input logic [CH-1:0] lv,
                                input logic [CH-1:0] bs, input int id);
        vec_t v;
        v.rst = r;  v.tk = tk; v.ht = ht; v.x = x;
        v.eq = q;   v.erel = rl; v.elev = lv; v.ebusy = bs; v.id = id;
        vecs.push_back(v);
    endfunction

    task automatic check_out();
        vec_t        e;
        logic [15:0] act, exp;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard step %0d: got empty queue, need one entry", step_no);
            return;
        end
        e   = sb.pop_front();
        act = {Q, REL, LEVEL, BUSY};
        exp = {e.eq, e.erel, e.elev, e.ebusy};
        n_cmp++;
        if (act !== exp)begin
            n_bad++;
            $display("FAIL %s step %0d: Q/REL/LEVEL/BUSY got %h/%h/%h/%h need %h/%h/%h/%h",
                     names[e.id], step_no, Q, REL, LEVEL, BUSY, e.eq, e.erel, e.elev, e.ebusy);
        end else begin
            $display("ok   %s step %0d: X=%h Q=%h REL=%h LEVEL=%h BUSY=%h",
                     names[e.id], step_no, e.x, Q, REL, LEVEL, BUSY);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset      = v.rst;
        tick       = v.tk;
        hold_ticks = v.ht;
        X          = v.x;
        sb.push_back(v);
        @(posedge clk);
        #1;
        step_no++;
        check_out();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, need $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tick = 1'b0; hold_ticks = '0; X = '0;

        // Reset with all inputs high, then 1-cycle holds on every channel.
        add(1, 1, 0, 4'hF, 0, 0, 0, 0, 0);
        add(1, 1, 0, 4'hF, 0, 0, 0, 0, 0);
        add(0, 1, 0, 4'hF, 4'hF, 0, 4'hF, 0, 0);
        add(0, 1, 0, 4'hF, 0, 0, 4'hF, 4'hF, 0);
        add(0, 1, 0, 4'hF, 0, 0, 4'hF, 0, 0);
        add(0, 1, 0, 4'h0, 0, 4'hF, 0, 0, 0);
        add(0, 1, 0, 4'h0, 0, 0, 0, 4'hF, 0);
        add(0, 1, 0, 4'h0, 0, 0, 0, 0, 0);

        // Basic press/release on channel 0, hold_ticks=3.
        add(0, 1, 3, 4'h1, 4'h1, 0, 4'h1, 0, 1);
        for (int i = 0; i < 4; i++)  add(0, 1, 3, 4'h1, 0, 0, 4'h1, 4'h1, 1);
        for (int i = 0; i < 15; i++) add(0, 1, 3, 4'h1, 0, 0, 4'h1, 0, 1);
        add(0, 1, 3, 4'h0, 0, 4'h1, 0, 0, 1);
        for (int i = 0; i < 4; i++)  add(0, 1, 3, 4'h0, 0, 0, 0, 4'h1, 1);
        add(0, 1, 3, 4'h0, 0, 0, 0, 0, 1);

        // Bounce on channel 1 during HOLD_HI, hold_ticks=5.
        for (int i = 0; i < 6; i++)
            add(0, 1, 5, (i % 2 == 0) ? 4'h2 : 4'h0, (i == 0) ? 4'h2 : 4'h0, 0, 4'h2,
                (i == 0) ? 4'h0 : 4'h2, 2);
        add(0, 1, 5, 4'h0, 0, 0, 4'h2, 4'h2, 2);
        add(0, 1, 5, 4'h0, 0, 0, 4'h2, 0, 2);
        add(0, 1, 5, 4'h0, 0, 4'h2, 0, 0, 2);
        for (int i = 0; i < 6; i++) add(0, 1, 5, 4'h0, 0, 0, 0, 4'h2, 2);
        add(0, 1, 5, 4'h0, 0, 0, 0, 0, 2);

        // Tick every 4th cycle on channel 2, hold_ticks=2.
        for (int t = 0; t <= 16; t++) begin
            logic          tk;
            logic [CH-1:0] xb, q, rl, lv, bs;
            tk = (t % 4 == 3);
            xb = (t <= 8) ? 4'h4 : 4'h0;
            q  = (t == 0) ? 4'h4 : 4'h0;
            rl = (t == 9) ? 4'h4 : 4'h0;
            lv = (t <= 8) ? 4'h4 : 4'h0;
            bs = ((t >= 1 && t <= 7) || (t >= 10 && t <= 15)) ? 4'h4 : 4'h0;
            add(0, tk, 2, xb, q, rl, lv, bs, 3);
        end

        // hold_ticks changes during holds on channel 3 do not affect the count.
        add(0, 1, 2, 4'h8, 4'h8, 0, 4'h8, 0, 4);
        add(0, 1, 2, 4'h8, 0, 0, 4'h8, 4'h8, 4);
        add(0, 1, 9, 4'h8, 0, 0, 4'h8, 4'h8, 4);
        add(0, 1, 9, 4'h8, 0, 0, 4'h8, 4'h8, 4);
        add(0, 1, 9, 4'h8, 0, 0, 4'h8, 0, 4);
        add(0, 1, 9, 4'h0, 0, 4'h8, 0, 0, 4);
        add(0, 1, 1, 4'h0, 0, 0, 0, 4'h8, 4);
        add(0, 1, 7, 4'h0, 0, 0, 0, 4'h8, 4);
        add(0, 1, 7, 4'h0, 0, 0, 0, 0, 4);

        // Simultaneous press on channels 0 and 2, hold_ticks=1.
        add(0, 1, 1, 4'h5, 4'h5, 0, 4'h5, 0, 5);
        add(0, 1, 1, 4'h5, 0, 0, 4'h5, 4'h5, 5);
        add(0, 1, 1, 4'h5, 0, 0, 4'h5, 4'h5, 5);
        add(0, 1, 1, 4'h5, 0, 0, 4'h5, 0, 5);
        add(0, 1, 1, 4'h0, 0, 4'h5, 0, 0, 5);
        add(0, 1, 1, 4'h0, 0, 0, 0, 4'h5, 5);
        add(0, 1, 1, 4'h0, 0, 0, 0, 4'h5, 5);
        add(0, 1, 1, 4'h0, 0, 0, 0, 0, 5);

        // Max hold with tick=0 never expires; X toggling is ignored; reset aborts it.
        add(0, 0, 16'hFFFF, 4'h1, 4'h1, 0, 4'h1, 0, 6);
        for (int i = 0; i < 40; i++)
            add(0, 0, 16'hFFFF, (i % 3 == 0) ? 4'h0 : 4'h1, 0, 0, 4'h1, 4'h1, 6);
        add(1, 0, 16'hFFFF, 4'h0, 0, 0, 0, 0, 6);
        add(0, 0, 16'hFFFF, 4'h0, 0, 0, 0, 0, 6);

        foreach (vecs[i]) apply(vecs[i]);

        // Hand-written: reset in the middle of HOLD_LO gives no REL pulse.
        begin
            vec_t v;
            v.id = 7; v.ht = 4; v.tk = 1'b1; v.rst = 1'b0;
            v.x = 4'h1; v.eq = 4'h1; v.erel = 0; v.elev = 4'h1; v.ebusy = 0;
            apply(v);
            v.eq = 0; v.ebusy = 4'h1;
            for (int i = 0; i < 5; i++) apply(v);
            v.ebusy = 0;
            apply(v);
            v.x = 0; v.erel = 4'h1; v.elev = 0;
            apply(v);
            v.erel = 0; v.ebusy = 4'h1;
            apply(v);
            apply(v);
            v.rst = 1'b1; v.ebusy = 0;
            apply(v);
            v.rst = 1'b0;
            apply(v);
            apply(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
